mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  Pipeline stage directly downstream of the EX/ALU stage. Consumes the registered ALU result
//  with its aligned IR/PC/operands and retires each instruction:
//  - LD/ST go through the data-memory req/ack handshake.
//  - ADD/MUL/LI/LD results are written to the register file.
//  - Branches issue a PC redirect.
//  Back-pressures EX via ex_ready, which drives the ALU load enable.
// PARAMETERS
//  DW           16   datapath width
//  AW           16   data-memory address width
//  MEM_TIMEOUT  255  max cycles to wait for dmem_ack; 0 = wait forever
// PORTS
//  CLK           in   1   clock, rising edge
//  RSTN          in   1   asynchronous, active-low reset
//  ex_valid      in   1   ex_* below hold a valid instruction
//  ex_ir         in   16  instruction aligned with ex_q
//  ex_q          in   DW  ALU result (data, or branch target)
//  ex_pc         in   16  sequential next-PC of the instruction
//  ex_sr1        in   DW  operand 1 (LD/ST address)
//  ex_sr2        in   DW  operand 2 (ST data)
//  ex_ready      out  1   stage consumes ex_* this cycle; ALU load enable
//  dmem_req      out  1   memory request, held until ack
//  dmem_we       out  1   1 = store, 0 = load
//  dmem_addr     out  AW  captured ex_sr1
//  dmem_wdata    out  DW  captured ex_sr2
//  dmem_rdata    in   DW  load data, valid with dmem_ack
//  dmem_ack      in   1   one-cycle completion pulse
//  rf_we         out  1   register-file write strobe (1 cycle)
//  rf_waddr      out  3   destination register, ir[13:11]
//  rf_wdata      out  DW  write data
//  redirect      out  1   1-cycle pulse: fetch must jump to redirect_pc
//  redirect_pc   out  16  branch target
//  mem_err       out  1   sticky: a memory access timed out
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, timeout counter 0. RSTN asserted mid-access drops
//    dmem_req asynchronously; the access is abandoned.
//  - ex_ready = (state == IDLE), combinational. Upstream holds ex_* stable while ex_ready = 0.
//  - An instruction is accepted on a clock edge where ex_valid & ex_ready.
//  - Decode (ir):
//      ST   00000_xxxxxx_00000
//      LD   00_xxx_xxx_00000001
//      ADD  00_xxx_xxx_xxx00010
//      MUL  00_xxx_xxx_xxx00011
//      LI   01_xxx_000_xxxxxxxx
//      B    10_000_000_x
//      BNZ  10001_x
//      BZ   10010_x
//      BGE  11_x
//    Priority follows this order; ST is checked before LD. Unmatched encodings retire as NOP.
//  - IDLE, accepting ADD/MUL/LI: next cycle rf_we = 1, rf_waddr = ir[13:11], rf_wdata = ex_q.
//  - IDLE, accepting a branch: next cycle redirect = 1, redirect_pc = ex_q, but only if
//    ex_q != ex_pc (not-taken branches produce ex_q == ex_pc). No rf write.
//  - IDLE, accepting LD/ST: capture addr, wdata, we and rd; dmem_req = 1 next cycle; go to MEM.
//  - MEM: dmem_req, dmem_we, dmem_addr and dmem_wdata held stable. The counter increments
//    every cycle.
//    - On dmem_ack: dmem_req = 0 next cycle, go to IDLE. For LD, the next cycle also has
//      rf_we = 1, rf_waddr = rd, rf_wdata = dmem_rdata.
//    - If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT without ack: dmem_req = 0,
//      mem_err = 1, no rf write, go to IDLE.
//    - dmem_ack and timeout in the same cycle: ack wins.
//  - dmem_ack outside MEM is ignored.
//  - Minimum occupancy:
//      ALU/branch op: 1 cycle.
//      LD/ST: 1 + N cycles, where N = cycle of ack, counted from the first dmem_req cycle.
//  - rf_we and redirect are never high in the same cycle. Writes to register 0 are allowed.
// STRUCTURE
//  - Include file cpu_isa.vh: opcode match patterns, field positions (RD = [13:11],
//    RS = [10:8]) and state encodings.
//  - Shared with the ALU and decode stages.
//  - One combinational sub-module, isa_decode: ir -> {is_ld, is_st, is_wb, is_br}.
//  - FSM, counter and output registers stay in this module.
// TESTING
//  1. ADD:
//     - Stimulus: ir = 16'b00_011_001_010_00010, ex_q = 16'h0007.
//     - Required: next cycle rf_we = 1, rf_waddr = 3, rf_wdata = 16'h0007; ex_ready stays 1.
//  2. LD:
//     - Stimulus: ir = 16'b00_101_010_00000001, ex_sr1 = 16'h0040; ack after 3 cycles with
//       rdata = 16'hBEEF.
//     - Required: dmem_req = 1, we = 0, addr = 16'h0040 for 3 cycles; ex_ready = 0 during the
//       access; then rf_we with rf_waddr = 5, rf_wdata = 16'hBEEF.
//  3. ST:
//     - Stimulus: ir = 16'h0000, ex_sr1 = 16'h0010, ex_sr2 = 16'h1234; immediate ack.
//     - Required: dmem_we = 1, wdata = 16'h1234; no rf_we; back to IDLE.
//  4. Branches:
//     - Taken BZ: ex_q = 16'h0020, ex_pc = 16'h0011 -> redirect = 1, redirect_pc = 16'h0020.
//     - Not-taken BNZ: ex_q = ex_pc = 16'h0011 -> no redirect.
//  5. Timeout:
//     - Stimulus: MEM_TIMEOUT = 4, LD with no ack.
//     - Required: dmem_req drops after 4 cycles; mem_err = 1 and stays set; no rf write.
//  6. Reset during access:
//     - Stimulus: RSTN low while in MEM.
//     - Required: dmem_req = 0 immediately; after release ex_ready = 1 and mem_err = 0.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: FSM states, instruction field
// positions and the decoded-instruction record.
package mem_wb_stage_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MEM  = 1'b1
  } state_e;

  localparam int RD_HI = 13;
  localparam int RD_LO = 11;
  localparam int RS_HI = 10;
  localparam int RS_LO = 8;

  typedef struct packed {
    logic is_ld;
    logic is_st;
    logic is_wb;
    logic is_br;
  } dec_t;

  function automatic logic [2:0] rd_field(input logic [15:0] ir);
    return ir[RD_HI:RD_LO];
  endfunction

endpackage

// File: rtl/mem_wb_stage_isa_decode.sv
// Combinational instruction classifier: maps an IR onto load/store,
// register write-back and branch classes; unmatched encodings decode as NOP.
module isa_decode
  import mem_wb_stage_pkg::*;
(
  input  logic [15:0] ir,
  output dec_t        dec
);

  logic st_s, ld_s, add_s, mul_s, li_s, b_s, bnz_s, bz_s, bge_s;

  assign st_s  = (ir[15:11] == 5'b00000) && (ir[4:0] == 5'b00000);
  assign ld_s  = (ir[15:14] == 2'b00) && (ir[7:0] == 8'b0000_0001);
  assign add_s = (ir[15:14] == 2'b00) && (ir[4:0] == 5'b00010);
  assign mul_s = (ir[15:14] == 2'b00) && (ir[4:0] == 5'b00011);
  assign li_s  = (ir[15:14] == 2'b01) && (ir[RS_HI:RS_LO] == 3'b000);
  assign b_s   = (ir[15:8] == 8'b1000_0000);
  assign bnz_s = (ir[15:11] == 5'b10001);
  assign bz_s  = (ir[15:11] == 5'b10010);
  assign bge_s = (ir[15:14] == 2'b11);

  // Priority chain: first matching class wins, ST ahead of LD.
  always_comb begin
    dec = 4'b0000;
    if (st_s) begin
      dec.is_st = 1'b1;
    end else if (ld_s) begin
      dec.is_ld = 1'b1;
    end else if (add_s || mul_s || li_s) begin
      dec.is_wb = 1'b1;
    end else if (b_s || bnz_s || bz_s || bge_s) begin
      dec.is_br = 1'b1;
    end else begin
      dec = 4'b0000;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: retires ALU results to the register file, runs LD/ST
// through the data-memory handshake with timeout, and issues branch redirects.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DW          = 16,
  parameter int AW          = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          ex_valid,
  input  logic [15:0]   ex_ir,
  input  logic [DW-1:0] ex_q,
  input  logic [15:0]   ex_pc,
  input  logic [DW-1:0] ex_sr1,
  input  logic [DW-1:0] ex_sr2,
  output logic          ex_ready,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic          rf_we,
  output logic [2:0]    rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          redirect,
  output logic [15:0]   redirect_pc,
  output logic          mem_err
);

  localparam bit          TO_EN  = (MEM_TIMEOUT != 0);
  localparam logic [15:0] TO_VAL = 16'(MEM_TIMEOUT);

  dec_t          dec_s;
  state_e        state_r, state_nxt_s;
  logic [15:0]   cnt_r, cnt_nxt_s, cnt_inc_s;
  logic          ld_r, ld_nxt_s;
  logic [2:0]    rd_r, rd_nxt_s;
  logic          req_nxt_s, we_nxt_s, rf_we_nxt_s, redir_nxt_s, err_nxt_s;
  logic [AW-1:0] addr_nxt_s;
  logic [DW-1:0] wdata_nxt_s, rf_wdata_nxt_s;
  logic [2:0]    rf_waddr_nxt_s;
  logic [15:0]   rpc_nxt_s;

  isa_decode u_dec (.ir(ex_ir), .dec(dec_s));

  assign ex_ready  = (state_r == S_IDLE);
  assign cnt_inc_s = cnt_r + 16'd1;

  // Next-state and next-output logic; pulse outputs default low every cycle.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    ld_nxt_s       = ld_r;
    rd_nxt_s       = rd_r;
    req_nxt_s      = dmem_req;
    we_nxt_s       = dmem_we;
    addr_nxt_s     = dmem_addr;
    wdata_nxt_s    = dmem_wdata;
    rf_we_nxt_s    = 1'b0;
    rf_waddr_nxt_s = rf_waddr;
    rf_wdata_nxt_s = rf_wdata;
    redir_nxt_s    = 1'b0;
    rpc_nxt_s      = redirect_pc;
    err_nxt_s      = mem_err;
    case (state_r)
      S_IDLE: begin
        if (ex_valid) begin
          if (dec_s.is_ld || dec_s.is_st) begin
            state_nxt_s = S_MEM;
            cnt_nxt_s   = 16'd0;
            req_nxt_s   = 1'b1;
            we_nxt_s    = dec_s.is_st;
            addr_nxt_s  = ex_sr1[AW-1:0];
            wdata_nxt_s = ex_sr2;
            ld_nxt_s    = dec_s.is_ld;
            rd_nxt_s    = rd_field(ex_ir);
          end else if (dec_s.is_wb) begin
            rf_we_nxt_s    = 1'b1;
            rf_waddr_nxt_s = rd_field(ex_ir);
            rf_wdata_nxt_s = ex_q;
          end else if (dec_s.is_br && (ex_q[15:0] != ex_pc)) begin
            // Not-taken branches arrive with target equal to the sequential PC.
            redir_nxt_s = 1'b1;
            rpc_nxt_s   = ex_q[15:0];
          end else begin
            state_nxt_s = S_IDLE;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_MEM: begin
        cnt_nxt_s = cnt_inc_s;
        if (dmem_ack) begin
          state_nxt_s = S_IDLE;
          cnt_nxt_s   = 16'd0;
          req_nxt_s   = 1'b0;
          if (ld_r) begin
            rf_we_nxt_s    = 1'b1;
            rf_waddr_nxt_s = rd_r;
            rf_wdata_nxt_s = dmem_rdata;
          end else begin
            rf_we_nxt_s = 1'b0;
          end
        end else if (TO_EN && (cnt_inc_s == TO_VAL)) begin
          state_nxt_s = S_IDLE;
          cnt_nxt_s   = 16'd0;
          req_nxt_s   = 1'b0;
          err_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = S_MEM;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = 16'd0;
        req_nxt_s   = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs; reset aborts any access in flight.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_r     <= S_IDLE;
      cnt_r       <= 16'd0;
      ld_r        <= 1'b0;
      rd_r        <= 3'd0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= 3'd0;
      rf_wdata    <= '0;
      redirect    <= 1'b0;
      redirect_pc <= 16'd0;
      mem_err     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      ld_r        <= ld_nxt_s;
      rd_r        <= rd_nxt_s;
      dmem_req    <= req_nxt_s;
      dmem_we     <= we_nxt_s;
      dmem_addr   <= addr_nxt_s;
      dmem_wdata  <= wdata_nxt_s;
      rf_we       <= rf_we_nxt_s;
      rf_waddr    <= rf_waddr_nxt_s;
      rf_wdata    <= rf_wdata_nxt_s;
      redirect    <= redir_nxt_s;
      redirect_pc <= rpc_nxt_s;
      mem_err     <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, hand-written
// memory/timeout/reset sequences and randomized instructions against a reference model.
module tb_mem_wb_stage;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        ex_valid;
  logic [15:0] ex_ir, ex_q, ex_pc, ex_sr1, ex_sr2;
  logic        ex_ready, dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack, rf_we, redirect, mem_err;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata, redirect_pc;

  int errors = 0;
  int checks = 0;
  logic exp_err = 1'b0;

  mem_wb_stage #(.DW(16), .AW(16), .MEM_TIMEOUT(TO)) dut (
    .CLK(CLK), .RSTN(RSTN), .ex_valid(ex_valid), .ex_ir(ex_ir), .ex_q(ex_q),
    .ex_pc(ex_pc), .ex_sr1(ex_sr1), .ex_sr2(ex_sr2), .ex_ready(ex_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  typedef enum int {C_NOP, C_ST, C_LD, C_WB, C_BR} cls_e;

  // Reference classification straight from the ISA pattern list, in priority order.
  function automatic cls_e ref_class(input logic [15:0] ir);
    casez (ir)
      16'b00000_??????_00000:  return C_ST;
      16'b00_???_???_00000001: return C_LD;
      16'b00_???_???_???00010: return C_WB;
      16'b00_???_???_???00011: return C_WB;
      16'b01_???_000_????????: return C_WB;
      16'b10_000_000_????????: return C_BR;
      16'b10001_???????????:   return C_BR;
      16'b10010_???????????:   return C_BR;
      16'b11_??????????????:   return C_BR;
      default:                 return C_NOP;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // One single-cycle instruction, expectations derived from the reference model.
  task automatic do_alu(input logic [15:0] ir, input logic [15:0] q, input logic [15:0] pc);
    cls_e c = ref_class(ir);
    logic taken = (c == C_BR) && (q != pc);
    ex_ir = ir; ex_q = q; ex_pc = pc; ex_valid = 1'b1;
    cyc();
    ex_valid = 1'b0;
    check("alu_rf_we", rf_we, (c == C_WB));
    check("alu_redirect", redirect, taken);
    check("alu_ready", ex_ready, 1'b1);
    if (c == C_WB) begin
      check("alu_waddr", rf_waddr, ir[13:11]);
      check("alu_wdata", rf_wdata, q);
    end
    if (taken) check("alu_rpc", redirect_pc, q);
  endtask

  // LD/ST access; ack arrives in req cycle d (1..TO), d == 0 means never.
  task automatic do_mem(input logic [15:0] ir, input logic [15:0] sr1, input logic [15:0] sr2,
                        input int d, input logic [15:0] rdata);
    cls_e c = ref_class(ir);
    logic acked = (d >= 1) && (d <= TO);
    ex_ir = ir; ex_sr1 = sr1; ex_sr2 = sr2; ex_q = 16'h5A5A; ex_pc = 16'h0001;
    ex_valid = 1'b1;
    cyc();
    ex_valid = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      check("mem_req", dmem_req, 1'b1);
      check("mem_we", dmem_we, (c == C_ST));
      check("mem_addr", dmem_addr, sr1);
      if (c == C_ST) check("mem_wdata", dmem_wdata, sr2);
      check("mem_ready", ex_ready, 1'b0);
      check("mem_no_rf", rf_we, 1'b0);
      if (k == d) begin
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
      end
      cyc();
      dmem_ack = 1'b0;
      if (k == d) break;
    end
    if (!acked) exp_err = 1'b1;
    check("mem_req_drop", dmem_req, 1'b0);
    check("mem_done_ready", ex_ready, 1'b1);
    check("mem_rf_we", rf_we, (c == C_LD) && acked);
    if ((c == C_LD) && acked) begin
      check("mem_waddr", rf_waddr, ir[13:11]);
      check("mem_wdata_rf", rf_wdata, rdata);
    end
    check("mem_err", mem_err, exp_err);
  endtask

  typedef struct {
    logic [15:0] ir, q, pc;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        rd;
    logic [15:0] rpc;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{16'b00_011_001_010_00010, 16'h0007, 16'h0001, 1'b1, 3'd3, 16'h0007, 1'b0, 16'h0000};
    tbl[1]  = '{16'b10010_00000000000,    16'h0020, 16'h0011, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0020};
    tbl[2]  = '{16'b10001_00000000000,    16'h0011, 16'h0011, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000};
    tbl[3]  = '{16'b01_110_000_10101010,  16'h00AA, 16'h0002, 1'b1, 3'd6, 16'h00AA, 1'b0, 16'h0000};
    tbl[4]  = '{16'b00_010_100_11100011,  16'h1234, 16'h0003, 1'b1, 3'd2, 16'h1234, 1'b0, 16'h0000};
    tbl[5]  = '{16'b10_000_000_00001111,  16'h0100, 16'h0050, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0100};
    tbl[6]  = '{16'hC123,                 16'h0003, 16'h0002, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0003};
    tbl[7]  = '{16'b00_000_000_00000100,  16'h0005, 16'h0006, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000};
    tbl[8]  = '{16'b00_000_111_11100010,  16'hFFFF, 16'h0004, 1'b1, 3'd0, 16'hFFFF, 1'b0, 16'h0000};
    tbl[9]  = '{16'b01_001_001_00000000,  16'h0009, 16'h0008, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000};
    tbl[10] = '{16'b10_000_001_00000000,  16'h0030, 16'h0008, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000};

    RSTN = 1'b0; ex_valid = 1'b0; ex_ir = 16'h0000; ex_q = 16'h0000; ex_pc = 16'h0000;
    ex_sr1 = 16'h0000; ex_sr2 = 16'h0000; dmem_rdata = 16'h0000; dmem_ack = 1'b0;
    #12;
    check("rst_ready", ex_ready, 1'b1);
    check("rst_req", dmem_req, 1'b0);
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_redirect", redirect, 1'b0);
    check("rst_err", mem_err, 1'b0);
    check("rst_outs", {dmem_we, dmem_addr, dmem_wdata, rf_waddr, rf_wdata, redirect_pc}, 32'h0);
    @(negedge CLK);
    RSTN = 1'b1;
    cyc();

    // Back-to-back single-cycle vectors, one accepted per clock.
    for (int i = 0; i < 11; i++) begin
      ex_ir = tbl[i].ir; ex_q = tbl[i].q; ex_pc = tbl[i].pc; ex_valid = 1'b1;
      cyc();
      check($sformatf("tbl%0d_rf_we", i), rf_we, tbl[i].we);
      check($sformatf("tbl%0d_redirect", i), redirect, tbl[i].rd);
      check($sformatf("tbl%0d_ready", i), ex_ready, 1'b1);
      if (tbl[i].we) begin
        check($sformatf("tbl%0d_waddr", i), rf_waddr, tbl[i].wa);
        check($sformatf("tbl%0d_wdata", i), rf_wdata, tbl[i].wd);
      end
      if (tbl[i].rd) check($sformatf("tbl%0d_rpc", i), redirect_pc, tbl[i].rpc);
    end
    ex_valid = 1'b0;

    // Ack while idle must be ignored.
    dmem_ack = 1'b1; dmem_rdata = 16'hDEAD;
    cyc();
    dmem_ack = 1'b0;
    check("stray_ack_req", dmem_req, 1'b0);
    check("stray_ack_rf", rf_we, 1'b0);
    check("stray_ack_ready", ex_ready, 1'b1);

    do_mem(16'b00_101_010_00000001, 16'h0040, 16'h0000, 3, 16'hBEEF);
    check("ld_waddr5", rf_waddr, 3'd5);
    check("ld_beef", rf_wdata, 16'hBEEF);
    do_mem(16'h0000, 16'h0010, 16'h1234, 1, 16'h0000);
    do_mem(16'b00_111_000_00000001, 16'h0022, 16'h0000, TO, 16'h0F0F);
    do_mem(16'b00_001_000_00000001, 16'h0033, 16'h0000, 0, 16'h0000);
    check("timeout_err", mem_err, 1'b1);
    do_alu(16'b00_100_000_00000010, 16'h0042, 16'h0000);
    check("err_sticky", mem_err, 1'b1);

    // Randomized instruction stream.
    for (int n = 0; n < 60; n++) begin
      logic [15:0] ir = 16'($urandom);
      logic [15:0] q  = 16'($urandom);
      logic [15:0] pc = 16'($urandom);
      int kind = $urandom_range(0, 5);
      case (kind)
        1: ir = {2'b00, ir[13:8], 8'h01};
        2: ir = {5'b00000, ir[10:5], 5'b00000};
        3: ir = {2'b00, ir[13:5], 4'b0001, ir[0]};
        4: ir = {2'b01, ir[13:11], 3'b000, ir[7:0]};
        5: if (ir[0]) q = pc;
        default: ;
      endcase
      if (ref_class(ir) == C_LD || ref_class(ir) == C_ST)
        do_mem(ir, 16'($urandom), 16'($urandom), $urandom_range(0, TO), 16'($urandom));
      else
        do_alu(ir, q, pc);
    end

    // Asynchronous reset in the middle of an access.
    ex_ir = 16'b00_010_011_00000001; ex_sr1 = 16'h0077; ex_valid = 1'b1;
    cyc();
    ex_valid = 1'b0;
    check("pre_rst_req", dmem_req, 1'b1);
    cyc();
    #2 RSTN = 1'b0;
    #1;
    check("async_rst_req", dmem_req, 1'b0);
    check("async_rst_ready", ex_ready, 1'b1);
    check("async_rst_err", mem_err, 1'b0);
    exp_err = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    cyc();
    check("post_rst_ready", ex_ready, 1'b1);
    check("post_rst_err", mem_err, 1'b0);
    check("post_rst_req", dmem_req, 1'b0);
    do_alu(16'b00_110_000_00000010, 16'h0066, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
